// File: rtl/alu_issue_ctrl.sv
// Issue front end between decode and the combinational ALU: one op at a time.
// ALU_MULDIV_EN builds the iterative MUL/SMUL/DIV/IDIV engine.
module alu_issue_ctrl #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [N-1:0] req_a,
    input  logic [N-1:0] req_b,
    input  logic [4:0]   req_aluop,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [4:0]   alu_aluop,
    input  logic [N-1:0] alu_final_sum,
    input  logic         alu_cout,
    input  logic         alu_negative_flag,
    input  logic         alu_overflow_flag,
    input  logic         alu_zero_flag,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_result,
    output logic         rsp_cout,
    output logic         rsp_negative_flag,
    output logic         rsp_overflow_flag,
    output logic         rsp_zero_flag,
    output logic         rsp_illegal_op,
    output logic         rsp_div_by_zero
);

    typedef enum logic [2:0] {
        IDLE, EXEC, RESP
`ifdef ALU_MULDIV_EN
        , MUL_IT, DIV_IT, FIXUP
`endif
    } state_t;

    state_t state;
    logic   op_bad;

    assign op_bad = (alu_aluop == 5'd0) || (alu_aluop > 5'd19);

`ifdef ALU_MULDIV_EN
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

    logic [N-1:0]   hi, lo, b_q;
    logic [CW-1:0]  cnt;
    logic [4:0]     op_q;
    logic           neg, dz, ovf_sp;
    logic           is_mul, is_div, sgn;
    logic [N-1:0]   abs_a, abs_b;
    logic [N:0]     m_sum, d_sh, d_diff;
    logic [2*N-1:0] prod, sprod;
    logic [N-1:0]   quot, fix_res;
    logic           fix_ovf, fix_neg;

    assign is_mul = (req_aluop == 5'd4) || (req_aluop == 5'd5);
    assign is_div = (req_aluop == 5'd6) || (req_aluop == 5'd7);
    assign sgn    = req_aluop[0];
    assign abs_a  = (sgn && req_a[N-1]) ? -req_a : req_a;
    assign abs_b  = (sgn && req_b[N-1]) ? -req_b : req_b;

    // hi:lo is the product during MUL_IT, remainder:quotient during DIV_IT
    assign m_sum  = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
    assign d_sh   = {hi, lo[N-1]};
    assign d_diff = d_sh - {1'b0, b_q};
    assign prod   = {hi, lo};
    assign sprod  = neg ? -prod : prod;
    assign quot   = neg ? -lo : lo;

    always_comb begin
        fix_res = lo;
        fix_ovf = 1'b0;
        fix_neg = 1'b0;
        unique case (1'b1)
            op_q == 5'd4: fix_ovf = |hi;
            op_q == 5'd5: begin
                fix_res = sprod[N-1:0];
                fix_ovf = !((&sprod[2*N-1:N-1]) || !(|sprod[2*N-1:N-1]));
                fix_neg = sprod[N-1];
            end
            op_q == 5'd7: begin
                fix_res = quot;
                fix_ovf = ovf_sp;
                fix_neg = quot[N-1];
            end
            default: ;
        endcase
    end
`else
    assign rsp_div_by_zero = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            req_ready         <= 1'b1;
            rsp_valid         <= 1'b0;
            alu_a             <= '0;
            alu_b             <= '0;
            alu_aluop         <= '0;
            rsp_result        <= '0;
            rsp_cout          <= 1'b0;
            rsp_negative_flag <= 1'b0;
            rsp_overflow_flag <= 1'b0;
            rsp_zero_flag     <= 1'b0;
            rsp_illegal_op    <= 1'b0;
`ifdef ALU_MULDIV_EN
            rsp_div_by_zero   <= 1'b0;
            hi                <= '0;
            lo                <= '0;
            b_q               <= '0;
            cnt               <= '0;
            op_q              <= '0;
            neg               <= 1'b0;
            dz                <= 1'b0;
            ovf_sp            <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: if (req_valid) begin
                    req_ready <= 1'b0;
`ifdef ALU_MULDIV_EN
                    if (is_mul || is_div) begin
                        op_q   <= req_aluop;
                        hi     <= '0;
                        lo     <= abs_a;
                        b_q    <= abs_b;
                        cnt    <= '0;
                        dz     <= 1'b0;
                        neg    <= sgn & (req_a[N-1] ^ req_b[N-1]);
                        ovf_sp <= (req_aluop == 5'd7) && (req_a == MIN_NEG)
                                  && (&req_b);
                        state  <= is_mul ? MUL_IT : DIV_IT;
                    end else
`endif
                    begin
                        alu_a     <= req_a;
                        alu_b     <= req_b;
                        alu_aluop <= req_aluop;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    alu_a     <= '0;
                    alu_b     <= '0;
                    alu_aluop <= '0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                    rsp_result        <= op_bad ? '0 : alu_final_sum;
                    rsp_cout          <= !op_bad && alu_cout;
                    rsp_negative_flag <= !op_bad && alu_negative_flag;
                    rsp_overflow_flag <= !op_bad && alu_overflow_flag;
                    rsp_zero_flag     <= !op_bad && alu_zero_flag;
                    rsp_illegal_op    <= op_bad;
`ifdef ALU_MULDIV_EN
                    rsp_div_by_zero   <= 1'b0;
`endif
                end
`ifdef ALU_MULDIV_EN
                MUL_IT: begin
                    {hi, lo} <= {m_sum, lo[N-1:1]};
                    cnt      <= cnt + 1'b1;
                    if (cnt == CW'(N-1)) state <= FIXUP;
                end
                DIV_IT: begin
                    if (b_q == '0) begin
                        lo    <= '1;
                        neg   <= 1'b0;
                        dz    <= 1'b1;
                        state <= FIXUP;
                    end else begin
                        hi  <= d_diff[N] ? d_sh[N-1:0] : d_diff[N-1:0];
                        lo  <= {lo[N-2:0], !d_diff[N]};
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(N-1)) state <= FIXUP;
                    end
                end
                FIXUP: begin
                    rsp_result        <= fix_res;
                    rsp_cout          <= 1'b0;
                    rsp_negative_flag <= fix_neg;
                    rsp_overflow_flag <= fix_ovf;
                    rsp_zero_flag     <= (fix_res == '0);
                    rsp_illegal_op    <= 1'b0;
                    rsp_div_by_zero   <= dz;
                    rsp_valid         <= 1'b1;
                    state             <= RESP;
                end
`endif
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Request/response front end that sits between the decode stage and the combinational 32-bit ALU, acting as the initiator side of the ALU's a/b/aluop interface.
- Accepts one operation at a time over a valid/ready request channel and drives the ALU from registered operands.
- Captures the ALU result and flags, and returns them over a valid/ready response channel.
- Executes MUL/SMUL/DIV/IDIV itself with an iterative 32-step engine, because the ALU returns 0 for MUL/SMUL/IDIV.

Parameters:
- N, 32, operand/result width. Iteration count equals N.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  high only in IDLE.
- req_a  input  N  operand a.
- req_b  input  N  operand b.
- req_aluop  input  5  opcode; same encoding as the ALU, 00001..10011.
- alu_a  output  N  to ALU a.
- alu_b  output  N  to ALU b.
- alu_aluop  output  5  to ALU aluop.
- alu_final_sum  input  N  from ALU.
- alu_cout, alu_negative_flag, alu_overflow_flag, alu_zero_flag  input  1 each  from ALU.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts.
- rsp_result  output  N  result.
- rsp_cout, rsp_negative_flag, rsp_overflow_flag, rsp_zero_flag  output  1 each.
- rsp_illegal_op  output  1  opcode outside 00001..10011.
- rsp_div_by_zero  output  1  DIV/IDIV with b==0.

Behaviour:
- Reset: state=IDLE; req_ready=1; rsp_valid=0; all rsp_* outputs, alu_* outputs, operand registers and iteration counter = 0.
- States: IDLE, EXEC, MUL_IT, DIV_IT, FIXUP, RESP.
- IDLE:
  - On req_valid & req_ready, latch a/b/aluop on the edge.
  - Next state: MUL_IT for 00100/00101, DIV_IT for 00110/00111, otherwise EXEC.
- EXEC:
  - alu_* driven from the latched registers; held stable during EXEC and zero otherwise.
  - On the next edge, capture alu_final_sum and the 4 flags into rsp_*, then go to RESP.
  - Illegal opcode (00000, 10100-11111): rsp_result=0, flags=0, rsp_illegal_op=1.
  - Latency: rsp_valid rises 2 edges after the accept edge.
- MUL_IT:
  - Shift-add over N edges on absolute values; SMUL takes magnitudes of signed operands.
  - Counter runs 0..N-1; at N-1 go to FIXUP.
- DIV_IT:
  - Restoring division, N edges, magnitudes for IDIV.
  - If b==0, skip iterations and go to FIXUP with quotient = all ones and rsp_div_by_zero=1.
- FIXUP (one edge):
  - Negate the result if the signed operand signs differ (SMUL/IDIV); keep the low N bits.
  - IDIV of 0x80000000 by 0xFFFFFFFF gives 0x80000000 with rsp_overflow_flag=1.
  - SMUL sets rsp_overflow_flag when the 2N-bit product does not fit in signed N bits.
  - MUL sets rsp_overflow_flag when the high N bits are nonzero.
  - rsp_zero_flag = (result==0).
  - rsp_negative_flag = result[N-1] for SMUL/IDIV, 0 for MUL/DIV.
  - rsp_cout = 0.
  - Multi-cycle latency: rsp_valid rises N+2 edges after the accept edge (34 for N=32).
- RESP:
  - rsp_valid=1; all rsp_* held stable until the rsp_valid & rsp_ready edge, then return to IDLE and clear rsp_valid.
  - No new request is accepted on the response-handshake edge; req_ready rises the cycle after.
- Backpressure: rsp_ready low holds RESP indefinitely with no change to outputs.
- req_valid while not IDLE is ignored; req_ready=0, so the request is not lost to the requester.
- Reset mid-operation: immediate return to reset values. The in-flight op is dropped and no response is produced.

Optional Feature:
- Macro: ALU_MULDIV_EN.
- Defined: MUL/SMUL/DIV/IDIV use the iterative engine as above.
- Undefined:
  - MUL_IT, DIV_IT and FIXUP are not built.
  - Opcodes 00100-00111 take the EXEC path like all other ops and return whatever the ALU produces.
  - rsp_div_by_zero is tied to 0.
  - Latency is 2 edges for every opcode.

Test Plan:
1. Reset, then a=5, b=7, aluop=00010 (ADD unsigned) with rsp_ready=1 -> rsp_valid 2 edges after accept; result=12, zero=0, cout=0, illegal=0.
2. a=0xFFFFFFFF, b=1, aluop=00010 -> result=0, zero_flag=1, overflow_flag=1 (from ALU cout).
3. ALU_MULDIV_EN, a=0xFFFFFFFD (-3), b=7, aluop=00101 (SMUL) -> after 34 edges result=0xFFFFFFEB, negative=1, overflow=0.
4. ALU_MULDIV_EN, aluop=00110, a=100, b=0 -> result=0xFFFFFFFF, div_by_zero=1.
5. ALU_MULDIV_EN, aluop=00111, a=0x80000000, b=0xFFFFFFFF -> result=0x80000000, overflow=1, negative=1.
6. aluop=10110 with rsp_ready=0 for 10 cycles:
   - illegal_op=1 and result=0, held stable the whole time.
   - Release rsp_ready -> one handshake, then req_ready=1.
   - Separately, pulse rst_n low during DIV_IT -> rsp_valid stays 0 and state returns to IDLE.
